scene_controller: RTL and testbench

- Parametrised scene/menu state machine for the game top level.
- Turns mouse position and button state into scene transitions: START, MENU, N play levels, WIN and LOSE.
- Adds the following on top of the existing single-click scene logic:
  - click edge detection
  - level-count generalisation
  - level unlock progression
  - win/lose handling with timeout return
  - hover and scene-entry outputs
- Sits between Mouse and Pixel_Gen/game logic; all ports are synchronous to the 100 MHz system clock.

---
 rtl/scene_pkg.sv | 48 ++++
 rtl/rect_hit.sv | 26 ++
 rtl/scene_controller.sv | 179 +++++++++++++++++
 tb/tb_scene_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scene_pkg.sv
// Shared scene codes, default screen geometry and width helpers for the
// scene/menu controller.
package scene_pkg;

    // Scene codes; the WIN/LOSE codes move with the number of levels.
    localparam int S_START     = 0;
    localparam int S_MENU      = 1;
    localparam int S_PLAY_BASE = 2;

    function automatic int s_win(input int num_levels);
        return num_levels + 2;
    endfunction

    function automatic int s_lose(input int num_levels);
        return num_levels + 3;
    endfunction

    // Default 640x480 screen layout.
    localparam int DEF_START_X0  = 200;
    localparam int DEF_START_X1  = 440;
    localparam int DEF_START_Y0  = 270;
    localparam int DEF_START_Y1  = 320;
    localparam int DEF_BTN_X0    = 160;
    localparam int DEF_BTN_X1    = 480;
    localparam int DEF_BTN_Y0    = 80;
    localparam int DEF_BTN_H     = 60;
    localparam int DEF_BTN_PITCH = 120;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int lvl_w(input int num_levels);
        return (clog2(num_levels) < 1) ? 1 : clog2(num_levels);
    endfunction

    typedef enum logic [2:0] {
        PH_START,
        PH_MENU,
        PH_PLAY,
        PH_WIN,
        PH_LOSE
    } phase_t;

endpackage

// File: rtl/rect_hit.sv
// Combinational point-in-rectangle test; low edges inclusive, high edges
// exclusive, compared at 11 bits so rectangle edges past 1023 never wrap.
module rect_hit #(
    parameter int X0 = 0,
    parameter int X1 = 0,
    parameter int Y0 = 0,
    parameter int Y1 = 0
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       hit
);

    localparam logic [10:0] LX0 = 11'(X0);
    localparam logic [10:0] LX1 = 11'(X1);
    localparam logic [10:0] LY0 = 11'(Y0);
    localparam logic [10:0] LY1 = 11'(Y1);

    logic [10:0] x11;
    logic [10:0] y11;

    assign x11 = {1'b0, x};
    assign y11 = {1'b0, y};
    assign hit = (x11 >= LX0) && (x11 < LX1) && (y11 >= LY0) && (y11 < LY1);

endmodule

// File: rtl/scene_controller.sv
// Scene/menu state machine: turns mouse clicks and game result pulses into
// START / MENU / PLAY(i) / WIN / LOSE transitions with level unlocking.
module scene_controller
    import scene_pkg::*;
#(
    parameter  int          NUM_LEVELS     = 3,
    parameter  int          LOCK_LEVELS    = 1,
    parameter  int          START_X0       = DEF_START_X0,
    parameter  int          START_X1       = DEF_START_X1,
    parameter  int          START_Y0       = DEF_START_Y0,
    parameter  int          START_Y1       = DEF_START_Y1,
    parameter  int          BTN_X0         = DEF_BTN_X0,
    parameter  int          BTN_X1         = DEF_BTN_X1,
    parameter  int          BTN_Y0         = DEF_BTN_Y0,
    parameter  int          BTN_H          = DEF_BTN_H,
    parameter  int          BTN_PITCH      = DEF_BTN_PITCH,
    parameter  int unsigned RESULT_TIMEOUT = 500_000_000,
    localparam int          SCENE_W        = clog2(NUM_LEVELS + 4),
    localparam int          LVL_W          = lvl_w(NUM_LEVELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            mouse_x,
    input  logic [9:0]            mouse_y,
    input  logic                  mouse_l,
    input  logic                  game_win,
    input  logic                  game_lose,
    input  logic                  game_quit,
    output logic [SCENE_W-1:0]    scene,
    output logic [LVL_W-1:0]      level,
    output logic                  scene_enter,
    output logic                  hover_valid,
    output logic [LVL_W-1:0]      hover_idx,
    output logic [NUM_LEVELS-1:0] unlocked
);

    localparam logic [NUM_LEVELS-1:0] UNLOCK_RST =
        (LOCK_LEVELS != 0) ? NUM_LEVELS'(1) : {NUM_LEVELS{1'b1}};

    phase_t                  state_q, state_d;
    logic [LVL_W-1:0]        level_d;
    logic [NUM_LEVELS-1:0]   unlocked_q, unlocked_d;
    logic [31:0]             timer_q, timer_d;
    logic                    mouse_l_d;
    logic                    click;
    logic                    start_hit;
    logic [NUM_LEVELS-1:0]   btn_hit;
    logic                    menu_hit;
    logic                    menu_open;
    logic [LVL_W-1:0]        menu_idx;
    logic                    hover_valid_d;
    logic [LVL_W-1:0]        hover_idx_d;

    rect_hit #(
        .X0(START_X0), .X1(START_X1), .Y0(START_Y0), .Y1(START_Y1)
    ) u_start_hit (
        .x  (mouse_x),
        .y  (mouse_y),
        .hit(start_hit)
    );

    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_btn
        rect_hit #(
            .X0(BTN_X0),
            .X1(BTN_X1),
            .Y0(BTN_Y0 + g * BTN_PITCH),
            .Y1(BTN_Y0 + g * BTN_PITCH + BTN_H)
        ) u_btn_hit (
            .x  (mouse_x),
            .y  (mouse_y),
            .hit(btn_hit[g])
        );
    end

    // Walk downward so the lowest overlapping button index is the one kept.
    always_comb begin
        menu_hit  = 1'b0;
        menu_open = 1'b0;
        menu_idx  = '0;
        for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
            if (btn_hit[i]) begin
                menu_hit  = 1'b1;
                menu_open = unlocked_q[i];
                menu_idx  = LVL_W'(i);
            end
        end
    end

    // mouse_l_d resets high so a button held through reset is not a click.
    assign click = mouse_l & ~mouse_l_d;

    always_comb begin
        state_d    = state_q;
        level_d    = level;
        unlocked_d = unlocked_q;
        timer_d    = '0;
        case (state_q)
            PH_START: begin
                if (click && start_hit) state_d = PH_MENU;
            end
            PH_MENU: begin
                if (click && menu_hit && menu_open) begin
                    state_d = PH_PLAY;
                    level_d = menu_idx;
                end
            end
            PH_PLAY: begin
                if (game_lose) begin
                    state_d = PH_LOSE;
                end else if (game_win) begin
                    state_d = PH_WIN;
                    for (int i = 1; i < NUM_LEVELS; i++) begin
                        if (int'(level) + 1 == i) unlocked_d[i] = 1'b1;
                    end
                end else if (game_quit) begin
                    state_d = PH_MENU;
                end
            end
            PH_WIN, PH_LOSE: begin
                if (click || (RESULT_TIMEOUT != 0 && timer_q == RESULT_TIMEOUT - 1))
                    state_d = PH_MENU;
                else
                    timer_d = timer_q + 32'd1;
            end
            default: state_d = PH_START;
        endcase
    end

    always_comb begin
        hover_valid_d = 1'b0;
        hover_idx_d   = '0;
        case (state_q)
            PH_START: hover_valid_d = start_hit;
            PH_MENU: begin
                if (menu_hit && menu_open) begin
                    hover_valid_d = 1'b1;
                    hover_idx_d   = menu_idx;
                end
            end
            default: hover_valid_d = 1'b0;
        endcase
    end

    always_comb begin
        case (state_q)
            PH_START: scene = SCENE_W'(S_START);
            PH_MENU:  scene = SCENE_W'(S_MENU);
            PH_PLAY:  scene = SCENE_W'(S_PLAY_BASE + int'(level));
            PH_WIN:   scene = SCENE_W'(s_win(NUM_LEVELS));
            PH_LOSE:  scene = SCENE_W'(s_lose(NUM_LEVELS));
            default:  scene = SCENE_W'(S_START);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PH_START;
            level       <= '0;
            unlocked_q  <= UNLOCK_RST;
            timer_q     <= '0;
            mouse_l_d   <= 1'b1;
            scene_enter <= 1'b0;
            hover_valid <= 1'b0;
            hover_idx   <= '0;
        end else begin
            state_q     <= state_d;
            level       <= level_d;
            unlocked_q  <= (LOCK_LEVELS != 0) ? unlocked_d : {NUM_LEVELS{1'b1}};
            timer_q     <= timer_d;
            mouse_l_d   <= mouse_l;
            scene_enter <= (state_d != state_q);
            hover_valid <= hover_valid_d;
            hover_idx   <= hover_idx_d;
        end
    end

    assign unlocked = unlocked_q;

endmodule

// File: tb/tb_scene_controller.sv
// Bench for scene_controller: directed walk through the scene flow, then
// randomized mouse/game stimulus against a cycle-level scene model.
module tb_scene_controller;

    localparam int NL = 3;
    localparam int TO = 10;
    localparam int W  = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] mouse_x, mouse_y;
    logic       mouse_l, game_win, game_lose, game_quit;
    logic [2:0] scene;
    logic [1:0] level, hover_idx;
    logic       scene_enter, hover_valid;
    logic [2:0] unlocked;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    // model state
    int m_scene, m_level, m_unl, m_timer, m_hi;
    bit m_ld, m_enter, m_hv;

    always #5 clk = ~clk;

    scene_controller #(
        .NUM_LEVELS(NL), .LOCK_LEVELS(1), .RESULT_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_l(mouse_l),
        .game_win(game_win), .game_lose(game_lose), .game_quit(game_quit),
        .scene(scene), .level(level), .scene_enter(scene_enter),
        .hover_valid(hover_valid), .hover_idx(hover_idx), .unlocked(unlocked)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_start(input int x, input int y);
        return x >= 200 && x < 440 && y >= 270 && y < 320;
    endfunction

    function automatic int btn_under(input int x, input int y);
        for (int i = 0; i < NL; i++)
            if (x >= 160 && x < 480 && y >= 80 + i * 120 && y < 80 + i * 120 + 60) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_scene = 0; m_level = 0; m_unl = 1; m_timer = 0;
        m_ld = 1'b1; m_enter = 1'b0; m_hv = 1'b0; m_hi = 0;
        exp_q.delete();
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit click;
        int b, nxt, x, y;
        x = int'(mouse_x);
        y = int'(mouse_y);
        click = mouse_l && !m_ld;
        b = btn_under(x, y);
        m_hv = 1'b0;
        m_hi = 0;
        if (m_scene == 0 && in_start(x, y)) m_hv = 1'b1;
        else if (m_scene == 1 && b >= 0 && ((m_unl >> b) & 1) != 0) begin
            m_hv = 1'b1;
            m_hi = b;
        end
        nxt = m_scene;
        if (m_scene == 0) begin
            if (click && in_start(x, y)) nxt = 1;
        end else if (m_scene == 1) begin
            if (click && b >= 0 && ((m_unl >> b) & 1) != 0) begin
                nxt = 2 + b;
                m_level = b;
            end
        end else if (m_scene < NL + 2) begin
            if (game_lose) nxt = NL + 3;
            else if (game_win) begin
                nxt = NL + 2;
                if (m_level + 1 < NL) m_unl = m_unl | (1 << (m_level + 1));
            end else if (game_quit) nxt = 1;
        end else begin
            if (click || m_timer == TO - 1) nxt = 1;
        end
        m_enter = (nxt != m_scene);
        if (nxt != m_scene) m_timer = 0;
        else if (m_scene >= NL + 2) m_timer++;
        m_scene = nxt;
        m_ld = mouse_l;
        exp_q.push_back({3'(m_scene), 2'(m_level), m_enter, m_hv, 2'(m_hi), 3'(m_unl)});
    endtask

    task automatic compare();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("scene", 32'(scene), 32'(e[11:9]));
        check("level", 32'(level), 32'(e[8:7]));
        check("scene_enter", 32'(scene_enter), 32'(e[6]));
        check("hover_valid", 32'(hover_valid), 32'(e[5]));
        if (e[5]) check("hover_idx", 32'(hover_idx), 32'(e[4:3]));
        check("unlocked", 32'(unlocked), 32'(e[2:0]));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic click_at(input int x, input int y);
        mouse_x = 10'(x);
        mouse_y = 10'(y);
        mouse_l = 1'b0;
        step();
        mouse_l = 1'b1;
        step();
    endtask

    task automatic pulse(input bit w, input bit lo, input bit q);
        game_win = w; game_lose = lo; game_quit = q;
        step();
        game_win = 1'b0; game_lose = 1'b0; game_quit = 1'b0;
    endtask

    task automatic rand_inputs();
        int k, b;
        int sx[5];
        int sy[5];
        sx = '{199, 200, 320, 439, 440};
        sy = '{269, 270, 300, 319, 320};
        k = $urandom_range(0, 9);
        if (k <= 1) begin
            mouse_x = 10'($urandom_range(0, 639));
            mouse_y = 10'($urandom_range(0, 479));
        end else if (k <= 3) begin
            mouse_x = 10'(sx[$urandom_range(0, 4)]);
            mouse_y = 10'(sy[$urandom_range(0, 4)]);
        end else begin
            b = $urandom_range(0, NL - 1);
            mouse_x = 10'($urandom_range(155, 485));
            mouse_y = 10'(78 + b * 120 + $urandom_range(0, 64));
        end
        if ($urandom_range(0, 2) == 0) mouse_l = ~mouse_l;
        game_win  = ($urandom_range(0, 11) == 0);
        game_lose = ($urandom_range(0, 13) == 0);
        game_quit = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        int n, ne;
        rst = 1'b1;
        mouse_l = 1'b1; mouse_x = 10'd300; mouse_y = 10'd300;
        game_win = 1'b0; game_lose = 1'b0; game_quit = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_scene", 32'(scene), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_enter", 32'(scene_enter), 32'd0);
        check("rst_hover_valid", 32'(hover_valid), 32'd0);
        check("rst_hover_idx", 32'(hover_idx), 32'd0);
        check("rst_unlocked", 32'(unlocked), 32'd1);
        rst = 1'b0;

        // button held through reset must not count as a click
        repeat (3) step();
        check("held_no_click", 32'(scene), 32'd0);
        mouse_l = 1'b0; step();
        mouse_l = 1'b1; step();
        check("start_to_menu", 32'(scene), 32'd1);
        check("enter_pulse", 32'(scene_enter), 32'd1);
        step();
        check("enter_one_cycle", 32'(scene_enter), 32'd0);

        click_at(320, 230);
        check("locked_stay", 32'(scene), 32'd1);
        click_at(320, 100);
        check("play0_scene", 32'(scene), 32'd2);
        check("play0_level", 32'(level), 32'd0);

        pulse(1'b1, 1'b0, 1'b0);
        check("win_scene", 32'(scene), 32'd5);
        check("win_unlock", 32'(unlocked), 32'd3);
        click_at(10, 10);
        check("win_click_menu", 32'(scene), 32'd1);
        click_at(320, 230);
        check("play1_scene", 32'(scene), 32'd3);
        check("play1_level", 32'(level), 32'd1);

        pulse(1'b1, 1'b1, 1'b0);
        check("lose_priority", 32'(scene), 32'd6);
        check("lose_no_unlock", 32'(unlocked), 32'd3);

        mouse_l = 1'b0;
        n = 0; ne = 0;
        while (scene != 3'd1 && n < 20) begin
            step();
            n++;
            if (scene_enter) ne++;
        end
        check("timeout_cycles", 32'(n), 32'd10);
        check("timeout_enter_count", 32'(ne), 32'd1);

        click_at(320, 230);
        pulse(1'b1, 1'b0, 1'b0);
        check("unlock_all", 32'(unlocked), 32'd7);
        click_at(10, 10);
        mouse_l = 1'b0; mouse_x = 10'd320; mouse_y = 10'd350;
        step();
        check("hover_btn2_valid", 32'(hover_valid), 32'd1);
        check("hover_btn2_idx", 32'(hover_idx), 32'd2);
        mouse_y = 10'd170;
        step();
        check("hover_gap", 32'(hover_valid), 32'd0);

        // reset in the middle of a level
        click_at(320, 350);
        check("play2_scene", 32'(scene), 32'd4);
        #2 rst = 1'b1;
        #1;
        check("midrst_scene", 32'(scene), 32'd0);
        check("midrst_unlocked", 32'(unlocked), 32'd1);
        check("midrst_level", 32'(level), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        repeat (4000) begin
            rand_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog expired at t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
